// File: rtl/pro_pkg.sv
// Shared constants and types for the pro_fcl sequencer and its result bank.
package pro_pkg;

  localparam int PRO_WIDTH    = 8;
  localparam int PRO_PARALLEL = 16;
  localparam int ACC_WIDTH    = 20;
  localparam int MAX_LEN      = 1024;

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(ACC_WIDTH);
  localparam int IW = $clog2(PRO_PARALLEL);

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, CAPTURE, DRAIN} pro_seq_state_e;

  typedef logic signed [PRO_WIDTH-1:0] pro_word_t;

endpackage

// File: rtl/pro_res_bank.sv
// Captures the PE array results in one cycle, then serializes them as a
// valid/ready word stream indexed by PE number.
module pro_res_bank
  import pro_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              capture_i,
  input  logic                              drain_i,
  input  logic [PRO_PARALLEL*PRO_WIDTH-1:0] pe_out_i,
  input  logic                              m_ready_i,
  output logic                              m_valid_o,
  output logic signed [PRO_WIDTH-1:0]       m_data_o,
  output logic [IW-1:0]                     m_idx_o,
  output logic                              m_last_o,
  output logic                              last_hs_o
);

  pro_word_t       bank_q [PRO_PARALLEL];
  logic [IW-1:0]   idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PRO_PARALLEL; i++) bank_q[i] <= '0;
    end else if (capture_i) begin
      for (int i = 0; i < PRO_PARALLEL; i++) bank_q[i] <= pe_out_i[i*PRO_WIDTH +: PRO_WIDTH];
    end
  end

  // The index parks at 0 between groups so the next drain starts at PE 0.
  always_comb begin
    idx_d = idx_q;
    if (capture_i) begin
      idx_d = '0;
    end else if (m_valid_o && m_ready_i) begin
      idx_d = m_last_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idx_q <= '0;
    else      idx_q <= idx_d;
  end

  assign m_valid_o = drain_i;
  assign m_data_o  = drain_i ? bank_q[idx_q] : '0;
  assign m_idx_o   = idx_q;
  assign m_last_o  = drain_i && (idx_q == IW'(PRO_PARALLEL - 1));
  assign last_hs_o = m_last_o && m_ready_i;

endmodule

// File: rtl/pro_fcl_seq.sv
// Per-group sequencer for the pro_fcl binary FC PE array: feeds pixels and
// weight words, clears accumulators on beat 0, then drains the shifted sums.
module pro_fcl_seq
  import pro_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start,
  input  logic [LW-1:0]                     cfg_in_len,
  input  logic [SW-1:0]                     cfg_shift,
  output logic                              busy,
  output logic                              done,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic signed [PRO_WIDTH-1:0]       s_data,
  output logic                              w_rd_en,
  output logic [LW-1:0]                     w_addr,
  input  logic [PRO_PARALLEL-1:0]           w_data,
  output logic signed [PRO_WIDTH-1:0]       pe_input,
  output logic [PRO_PARALLEL-1:0]           pe_w,
  output logic                              pe_acc_clr_n,
  output logic [SW-1:0]                     pe_shift,
  input  logic [PRO_PARALLEL*PRO_WIDTH-1:0] pe_out,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic signed [PRO_WIDTH-1:0]       m_data,
  output logic [IW-1:0]                     m_idx,
  output logic                              m_last
);

  pro_seq_state_e state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  shift_q, shift_d;
  pro_word_t      pix_q, pix_d;
  logic           beat_vld_q, beat_vld_d;
  logic           first_q, first_d;
  logic           done_q, done_d;
  logic           beat_hs, last_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      pix_q      <= '0;
      beat_vld_q <= 1'b0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      pix_q      <= pix_d;
      beat_vld_q <= beat_vld_d;
      first_q    <= first_d;
      done_q     <= done_d;
    end
  end

  assign s_ready = (state_q == FEED) && (cnt_q != len_q);
  assign beat_hs = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    pix_d      = pix_q;
    beat_vld_d = 1'b0;
    first_d    = 1'b0;
    done_d     = 1'b0;
    w_rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          len_d   = cfg_in_len;
          shift_d = cfg_shift;
          cnt_d   = '0;
          if (cfg_in_len == '0) done_d  = 1'b1;
          else                  state_d = FEED;
        end
      end
      FEED: begin
        // The weight read issues with the handshake so its data lines up
        // with the registered pixel in the following cycle.
        if (beat_hs) begin
          w_rd_en    = 1'b1;
          pix_d      = s_data;
          beat_vld_d = 1'b1;
          first_d    = (cnt_q == '0);
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == len_q - LW'(1)) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = CAPTURE;
      CAPTURE: state_d = DRAIN;
      DRAIN: begin
        if (last_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Non-beat cycles present a zero pixel, which the array treats as neutral.
  assign pe_input     = beat_vld_q ? pix_q : '0;
  assign pe_w         = beat_vld_q ? w_data : '0;
  assign pe_acc_clr_n = !(beat_vld_q && first_q);
  assign pe_shift     = shift_q;
  assign w_addr       = cnt_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  pro_res_bank u_bank (
    .clk       (clk),
    .rst       (rst),
    .capture_i (state_q == CAPTURE),
    .drain_i   (state_q == DRAIN),
    .pe_out_i  (pe_out),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_idx_o   (m_idx),
    .m_last_o  (m_last),
    .last_hs_o (last_hs)
  );

endmodule

// File: tb/tb_pro_fcl_seq.sv
// Bench for pro_fcl_seq: PE array and weight RAM models around the DUT,
// vector table with hand-derived results, corner sequences and random groups.
module tb_pro_fcl_seq;
  import pro_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst = 1'b0;
  logic                              cfg_start = 1'b0;
  logic [LW-1:0]                     cfg_in_len = '0;
  logic [SW-1:0]                     cfg_shift = '0;
  logic                              busy, done;
  logic                              s_valid = 1'b0;
  logic                              s_ready;
  logic signed [PRO_WIDTH-1:0]       s_data = '0;
  logic                              w_rd_en;
  logic [LW-1:0]                     w_addr;
  logic [PRO_PARALLEL-1:0]           w_data = '0;
  logic signed [PRO_WIDTH-1:0]       pe_input;
  logic [PRO_PARALLEL-1:0]           pe_w;
  logic                              pe_acc_clr_n;
  logic [SW-1:0]                     pe_shift;
  logic [PRO_PARALLEL*PRO_WIDTH-1:0] pe_out;
  logic                              m_valid;
  logic                              m_ready = 1'b0;
  logic signed [PRO_WIDTH-1:0]       m_data;
  logic [IW-1:0]                     m_idx;
  logic                              m_last;

  always #5 clk = ~clk;

  pro_fcl_seq dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_in_len(cfg_in_len),
    .cfg_shift(cfg_shift), .busy(busy), .done(done), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .w_data(w_data), .pe_input(pe_input), .pe_w(pe_w), .pe_acc_clr_n(pe_acc_clr_n),
    .pe_shift(pe_shift), .pe_out(pe_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last)
  );

  // Environment: synchronous-read weight RAM and the accumulating PE array.
  logic [PRO_PARALLEL-1:0] w_ram [2**LW];
  always @(posedge clk) if (w_rd_en) w_data <= w_ram[w_addr];

  logic signed [ACC_WIDTH-1:0] acc [PRO_PARALLEL];
  logic signed [ACC_WIDTH-1:0] pix_ext;
  assign pix_ext = {{(ACC_WIDTH-PRO_WIDTH){pe_input[PRO_WIDTH-1]}}, pe_input};
  always @(posedge clk)
    for (int i = 0; i < PRO_PARALLEL; i++)
      acc[i] <= (pe_acc_clr_n ? acc[i] : '0) + (pe_w[i] ? pix_ext : -pix_ext);
  generate
    for (genvar gi = 0; gi < PRO_PARALLEL; gi++) begin : g_pe
      assign pe_out[gi*PRO_WIDTH +: PRO_WIDTH] = PRO_WIDTH'(acc[gi] >>> pe_shift);
    end
  endgenerate

  typedef struct packed {
    logic [10:0]     len;
    logic [4:0]      shift;
    logic [3:0][7:0] pix;
    logic [15:0]     w;
    logic [3:0]      gap;
    logic [4:0]      stall_idx;
    logic [3:0]      stall_len;
    logic [7:0]      exp_even;
    logic [7:0]      exp_odd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  int                      g_len, g_shift, g_gap, g_stall_idx, g_stall_len;
  bit                      g_rand = 0;
  bit                      g_start_in_drain = 0;
  int                      g_pix [32];
  logic [PRO_PARALLEL-1:0] g_w [32];
  int                      exp_word [PRO_PARALLEL];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_w_rd_en"}, w_rd_en, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_pe_input"}, pe_input, 0);
    chk({tag, "_pe_w"}, pe_w, 0);
    chk({tag, "_pe_acc_clr_n"}, pe_acc_clr_n, 1);
    chk({tag, "_pe_shift"}, pe_shift, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_idx"}, m_idx, 0);
    chk({tag, "_m_last"}, m_last, 0);
  endtask

  task automatic load_row(input vec_t v);
    g_len = int'(v.len); g_shift = int'(v.shift); g_gap = int'(v.gap);
    g_stall_idx = int'(v.stall_idx); g_stall_len = int'(v.stall_len);
    g_rand = 0; g_start_in_drain = 0;
    for (int b = 0; b < 4; b++) begin
      g_pix[b] = int'($signed(v.pix[b]));
      g_w[b]   = v.w;
    end
    for (int i = 0; i < PRO_PARALLEL; i++)
      exp_word[i] = (i % 2 == 1) ? int'($signed(v.exp_odd)) : int'($signed(v.exp_even));
  endtask

  // Reference: each PE sums +P or -P per beat, then takes the arithmetic shift.
  task automatic ref_model();
    int sum;
    logic signed [PRO_WIDTH-1:0] t;
    for (int i = 0; i < PRO_PARALLEL; i++) begin
      sum = 0;
      for (int b = 0; b < g_len; b++) sum += g_w[b][i] ? g_pix[b] : -g_pix[b];
      t = PRO_WIDTH'(sum >>> g_shift);
      exp_word[i] = int'(t);
    end
  endtask

  task automatic run_group(input string name);
    int beat, nrx, cyc, hs_cyc, first_v, last_cyc, done_cnt, done_cyc, gap_left, stall_cnt;
    bit prev_stall, pulsed;
    logic signed [PRO_WIDTH-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    beat = 0; nrx = 0; cyc = 0; hs_cyc = -100; first_v = -1; last_cyc = -100;
    done_cnt = 0; done_cyc = -100; gap_left = 0; stall_cnt = 0;
    prev_stall = 0; pulsed = 0; prev_data = '0; prev_idx = '0;
    for (int b = 0; b < g_len; b++) w_ram[b] = g_w[b];
    @(negedge clk);
    cfg_in_len = LW'(g_len);
    cfg_shift  = SW'(g_shift);
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    while (cyc < 1000 && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
      if (beat < g_len) begin
        s_valid = g_rand ? 1'($urandom_range(0, 1)) : (gap_left == 0);
        s_data  = PRO_WIDTH'(g_pix[beat]);
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
      end
      if (g_rand) m_ready = ($urandom_range(0, 3) != 0);
      else        m_ready = !(nrx == g_stall_idx && stall_cnt < g_stall_len);
      cfg_start = g_start_in_drain && first_v >= 0 && !pulsed;
      #1;
      if (cfg_start) pulsed = 1;
      if (s_valid && s_ready) begin
        chk("w_rd_en", w_rd_en, 1);
        chk("w_addr", w_addr, beat);
        beat++;
        hs_cyc = cyc;
        gap_left = g_gap;
      end else if (!s_valid && gap_left > 0) begin
        gap_left--;
      end
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_idx", m_idx, prev_idx);
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        if (nrx < PRO_PARALLEL) begin
          chk("m_idx", m_idx, nrx);
          chk("m_last", m_last, (nrx == PRO_PARALLEL - 1));
          chk("m_data", m_data, exp_word[nrx]);
        end else begin
          chk("extra_word", nrx, PRO_PARALLEL - 1);
        end
        if (m_last) last_cyc = cyc;
        nrx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_idx   = m_idx;
      if (m_valid && !m_ready) stall_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    chk("beats", beat, g_len);
    chk("words", nrx, PRO_PARALLEL);
    chk("done_count", done_cnt, 1);
    chk("done_timing", done_cyc, last_cyc + 1);
    chk("latency", first_v - hs_cyc, 3);
    #1 chk("idle_after", busy, 0);
    if (!g_rand) chk("stall_cycles", stall_cnt, g_stall_len);
    $display("[TB] group %s len=%0d shift=%0d words=%0d done=%0d cycles=%0d",
             name, g_len, g_shift, nrx, done_cnt, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   mv, dn;
    vt[0] = '{len:11'd4, shift:5'd0, pix:32'h281E140A, w:16'hFFFF, gap:4'd0, stall_idx:5'd31, stall_len:4'd0, exp_even:8'd100,  exp_odd:8'd100};
    vt[1] = '{len:11'd4, shift:5'd0, pix:32'h281E140A, w:16'h5555, gap:4'd0, stall_idx:5'd31, stall_len:4'd0, exp_even:8'd100,  exp_odd:8'h9C};
    vt[2] = '{len:11'd4, shift:5'd0, pix:32'h281E140A, w:16'hFFFF, gap:4'd3, stall_idx:5'd31, stall_len:4'd0, exp_even:8'd100,  exp_odd:8'd100};
    vt[3] = '{len:11'd4, shift:5'd0, pix:32'h281E140A, w:16'hFFFF, gap:4'd0, stall_idx:5'd7,  stall_len:4'd5, exp_even:8'd100,  exp_odd:8'd100};
    vt[4] = '{len:11'd4, shift:5'd1, pix:32'h281E140A, w:16'h0000, gap:4'd1, stall_idx:5'd31, stall_len:4'd0, exp_even:8'hCE,   exp_odd:8'hCE};
    vt[5] = '{len:11'd2, shift:5'd0, pix:32'h00001B64, w:16'hFFFF, gap:4'd0, stall_idx:5'd15, stall_len:4'd2, exp_even:8'h7F,   exp_odd:8'h7F};
    vt[6] = '{len:11'd1, shift:5'd0, pix:32'h0000007F, w:16'hAAAA, gap:4'd0, stall_idx:5'd0,  stall_len:4'd3, exp_even:8'h81,   exp_odd:8'h7F};
    vt[7] = '{len:11'd4, shift:5'd2, pix:32'h281E140A, w:16'hFFFF, gap:4'd0, stall_idx:5'd31, stall_len:4'd0, exp_even:8'd25,   exp_odd:8'd25};

    repeat (2) @(negedge clk);
    #1 chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int r = 0; r < 7; r++) begin
      load_row(vt[r]);
      run_group($sformatf("vec%0d", r));
    end

    load_row(vt[0]);
    g_start_in_drain = 1;
    run_group("start_in_drain");
    g_start_in_drain = 0;

    // Zero-length group: done one cycle after start, no output words.
    @(negedge clk);
    cfg_in_len = '0;
    cfg_shift  = '0;
    cfg_start  = 1'b1;
    #1 chk("len0_busy_start", busy, 0);
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    mv = int'(m_valid);
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      mv += int'(m_valid);
      dn += int'(done);
    end
    chk("len0_m_valid", mv, 0);
    chk("len0_done_once", dn, 0);
    $display("[TB] group len0 m_valid_cycles=%0d extra_done=%0d", mv, dn);

    for (int r = 0; r < 6; r++) begin
      g_len = int'($urandom_range(1, 12));
      g_shift = int'($urandom_range(0, 3));
      g_rand = 1;
      g_stall_len = 0;
      g_stall_idx = 31;
      g_gap = 0;
      for (int b = 0; b < g_len; b++) begin
        g_pix[b] = int'($signed(8'($urandom_range(0, 255))));
        g_w[b]   = 16'($urandom);
      end
      ref_model();
      run_group($sformatf("rand%0d", r));
    end
    g_rand = 0;

    // Reset in the middle of FEED, then rerun with a shift to prove beat 0 clears.
    @(negedge clk);
    cfg_in_len = LW'(4);
    cfg_shift  = SW'(1);
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    s_valid   = 1'b1;
    s_data    = 8'sd55;
    repeat (2) @(negedge clk);
    #1 chk("busy_pre_rst", busy, 1);
    rst = 1'b0;
    s_valid = 1'b0;
    #1 chk_reset("rst_mid_feed");
    @(negedge clk);
    rst = 1'b1;
    load_row(vt[7]);
    run_group("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
